// File: rtl/line_window_ctrl_pkg.sv
`default_nettype none
// line_window_ctrl_pkg: shared geometry defaults, read FSM states and ring-index helper.
package line_window_ctrl_pkg;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_LINE_W = 512;
  localparam int DEF_WIN    = 6;
  localparam int DEF_NUM_LB = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_LINE  = 2'd1,
    RD_FLUSH = 2'd2
  } rd_state_t;

  // (base + off) mod n, valid for base < n and off < n.
  function automatic int ring_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_window_ctrl_linebuffer.sv
`default_nettype none
// lineBuffer: one line of pixel storage with a write pointer and TAPS consecutive read taps.
module lineBuffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 512,
  parameter int TAPS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PIX_W-1:0]      wr_data,
  input  logic                  rd_adv,
  output logic [TAPS*PIX_W-1:0] taps
);

  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (rd_adv) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
    end
  end

  // Contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    logic [AW:0] idx;
    assign idx = {1'b0, rd_ptr} + (AW+1)'(t);
    assign taps[t*PIX_W +: PIX_W] =
      mem[(idx >= (AW+1)'(DEPTH)) ? AW'(idx - (AW+1)'(DEPTH)) : idx[AW-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/line_window_ctrl.sv
`default_nettype none
// line_window_ctrl: round-robin line buffer ring feeding sliding WIN x WIN pixel windows.
module line_window_ctrl
  import line_window_ctrl_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int WIN    = DEF_WIN,
  parameter int NUM_LB = DEF_NUM_LB
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [PIX_W-1:0]         i_pixel_data,
  input  logic                     i_pixel_valid,
  output logic                     o_pixel_ready,
  output logic [WIN*WIN*PIX_W-1:0] o_window,
  output logic                     o_window_valid,
  input  logic                     i_window_ready,
  output logic                     o_line_done,
  output logic                     o_overflow
);

  localparam int LBW = $clog2(NUM_LB);
  localparam int CW  = $clog2(LINE_W);
  localparam int FW  = $clog2(NUM_LB + 1);

  logic [CW-1:0]        wr_cnt, rd_cnt, rd_cnt_nxt;
  logic [LBW-1:0]       wr_lb, rd_lb, rd_lb_nxt;
  logic [FW-1:0]        lines_full;
  rd_state_t            state, state_nxt;
  logic                 arm;
  logic                 accept, wr_line_end, retire, rd_adv;
  logic                 lb_rst;
  logic [NUM_LB-1:0]    lb_wr_en, lb_rd_adv;
  logic [WIN*PIX_W-1:0] lb_taps [NUM_LB];

  assign o_pixel_ready = (lines_full < FW'(NUM_LB));
  assign accept        = i_pixel_valid & o_pixel_ready;
  assign wr_line_end   = accept && (wr_cnt == CW'(LINE_W-1));
  assign lb_rst        = ~i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_cnt     <= '0;
      wr_lb      <= '0;
      lines_full <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (accept) wr_cnt <= wr_line_end ? '0 : wr_cnt + CW'(1);
      if (wr_line_end) wr_lb <= LBW'(ring_idx(int'(wr_lb), 1, NUM_LB));
      if (wr_line_end && !retire)      lines_full <= lines_full + FW'(1);
      else if (!wr_line_end && retire) lines_full <= lines_full - FW'(1);
      if (i_pixel_valid && !o_pixel_ready) o_overflow <= 1'b1;
    end
  end

  // arm delays the IDLE exit by one cycle so the line just completed has settled in memory.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      rd_cnt <= '0;
      rd_lb  <= '0;
      arm    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      rd_lb  <= rd_lb_nxt;
      arm    <= (state == IDLE) && (lines_full >= FW'(WIN));
    end
  end

  always_comb begin
    state_nxt      = state;
    rd_cnt_nxt     = rd_cnt;
    rd_lb_nxt      = rd_lb;
    o_window_valid = 1'b0;
    o_line_done    = 1'b0;
    rd_adv         = 1'b0;
    retire         = 1'b0;
    case (state)
      IDLE: begin
        if (arm && (lines_full >= FW'(WIN))) begin
          state_nxt  = RD_LINE;
          rd_cnt_nxt = '0;
        end
      end
      RD_LINE: begin
        o_window_valid = 1'b1;
        if (i_window_ready) begin
          rd_adv = 1'b1;
          if (rd_cnt == CW'(LINE_W-WIN)) begin
            state_nxt  = RD_FLUSH;
            rd_cnt_nxt = '0;
          end else begin
            rd_cnt_nxt = rd_cnt + CW'(1);
          end
        end
      end
      RD_FLUSH: begin
        // Walk the read pointers of the active buffers the rest of the way back to 0.
        rd_adv = 1'b1;
        if (rd_cnt == CW'(WIN-2)) begin
          o_line_done = 1'b1;
          retire      = 1'b1;
          rd_lb_nxt   = LBW'(ring_idx(int'(rd_lb), 1, NUM_LB));
          state_nxt   = IDLE;
          rd_cnt_nxt  = '0;
        end else begin
          rd_cnt_nxt = rd_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lb_wr_en        = '0;
    lb_rd_adv       = '0;
    lb_wr_en[wr_lb] = accept;
    for (int r = 0; r < WIN; r++)
      lb_rd_adv[LBW'(ring_idx(int'(rd_lb), r, NUM_LB))] = rd_adv;
  end

  always_comb begin
    o_window = '0;
    for (int r = 0; r < WIN; r++)
      o_window[r*WIN*PIX_W +: WIN*PIX_W] = lb_taps[LBW'(ring_idx(int'(rd_lb), r, NUM_LB))];
  end

  for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
    lineBuffer #(
      .PIX_W (PIX_W),
      .DEPTH (LINE_W),
      .TAPS  (WIN)
    ) u_lb (
      .clk     (i_clk),
      .rst     (lb_rst),
      .wr_en   (lb_wr_en[g]),
      .wr_data (i_pixel_data),
      .rd_adv  (lb_rd_adv[g]),
      .taps    (lb_taps[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_line_window_ctrl.sv
`default_nettype none
// tb_line_window_ctrl: line-level reference model, randomized pixel data, per-scenario tasks.
`timescale 1ns/1ps
module tb_line_window_ctrl;

  localparam int PW   = 8;
  localparam int LW   = 512;
  localparam int W    = 6;
  localparam int NL   = 7;
  localparam int NWIN = LW - W + 1;
  localparam int MAXL = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PW-1:0]     pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [W*W*PW-1:0] window;
  logic              win_valid;
  logic              win_ready;
  logic              line_done;
  logic              overflow;

  always #5 clk = ~clk;

  line_window_ctrl #(.PIX_W(PW), .LINE_W(LW), .WIN(W), .NUM_LB(NL)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pixel_data   (pix_data),
    .i_pixel_valid  (pix_valid),
    .o_pixel_ready  (pix_ready),
    .o_window       (window),
    .o_window_valid (win_valid),
    .i_window_ready (win_ready),
    .o_line_done    (line_done),
    .o_overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: every accepted pixel by global line/column; reader position as (pass, column).
  logic [PW-1:0] lines [MAXL][LW];
  int acc_cnt, feed_target, edge6, rd_pass, rd_col;
  bit rand_src;

  function automatic logic [PW-1:0] src_pix(input int n);
    if (rand_src) return PW'($urandom);
    return PW'((7 * (n / LW) + n % LW) % 256);
  endfunction

  function automatic logic [W*W*PW-1:0] win_expected(input int p, input int k);
    logic [W*W*PW-1:0] e;
    e = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        e[(r*W+c)*PW +: PW] = lines[p+r][k+c];
    return e;
  endfunction

  task automatic tick();
    if (pix_valid && pix_ready) begin
      lines[acc_cnt/LW][acc_cnt%LW] = pix_data;
      acc_cnt++;
      if (acc_cnt == W*LW) edge6 = cyc + 1;
    end
    @(posedge clk);
    @(negedge clk);
    pix_valid = (acc_cnt < feed_target) && pix_ready;
    pix_data  = src_pix(acc_cnt);
  endtask

  task automatic start_feed(input int target, input bit rnd);
    rand_src    = rnd;
    feed_target = target;
    pix_valid   = (acc_cnt < feed_target) && pix_ready;
    pix_data    = src_pix(acc_cnt);
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    pix_data  = '0;
    win_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc_cnt = 0; feed_target = 0; edge6 = -1; rd_pass = 0; rd_col = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", win_valid); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done: got %b expected 0", line_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pixel_ready: got %b expected 1", pix_ready); end
  endtask

  task automatic test_stream();
    int first_v = -1, last_v = -1, done_c = -1, nwin = 0, extra = 0;
    bit bad = 0;
    logic [W*W*PW-1:0] exp;
    do_reset();
    win_ready = 1'b1;
    start_feed(W*LW, 1'b0);
    for (int i = 0; i < 5000 && done_c < 0; i++) begin
      if (win_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
              if (window[(r*W+c)*PW +: PW] !== PW'(7*r+c)) bad = 1;
          checks++; if (bad) begin errors++; $display("FAIL stream_first_window: got %h expected row r col c = 7r+c", window); end
        end
        last_v = cyc;
      end
      if (line_done) done_c = cyc;
      if (win_valid && win_ready) begin
        exp = win_expected(rd_pass, rd_col);
        checks++; if (window !== exp) begin errors++; $display("FAIL stream_window p%0d k%0d: got %h expected %h", rd_pass, rd_col, window, exp); end
        nwin++; rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      if (win_valid || line_done) extra++;
      tick();
    end
    checks++; if (done_c < 0) begin errors++; $display("FAIL stream_timeout: got no line_done expected one"); end
    checks++; if (first_v - edge6 !== 2) begin errors++; $display("FAIL stream_latency: got %0d edges expected 2", first_v - edge6); end
    checks++; if (nwin !== NWIN) begin errors++; $display("FAIL stream_window_count: got %0d expected %0d", nwin, NWIN); end
    checks++; if (done_c - last_v !== W-1) begin errors++; $display("FAIL stream_flush_len: got %0d expected %0d", done_c - last_v, W-1); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL stream_idle_after: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_continuous();
    int ndone = 0, nwin = 0, max_lf = 0;
    logic [W*W*PW-1:0] exp;
    do_reset();
    win_ready = 1'b1;
    start_feed(8*LW, 1'b0);
    for (int i = 0; i < 8000 && ndone < 3; i++) begin
      if (int'(dut.lines_full) > max_lf) max_lf = int'(dut.lines_full);
      if (line_done) ndone++;
      if (win_valid && win_ready) begin
        if (rd_col == 0 && rd_pass > 0) begin
          checks++;
          if (window[PW-1:0] !== PW'(7*rd_pass)) begin errors++; $display("FAIL cont_pass_start p%0d: got %0d expected %0d", rd_pass, window[PW-1:0], 7*rd_pass); end
        end
        exp = win_expected(rd_pass, rd_col);
        checks++; if (window !== exp) begin errors++; $display("FAIL cont_window p%0d k%0d: got %h expected %h", rd_pass, rd_col, window, exp); end
        nwin++; rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
    end
    checks++; if (ndone !== 3) begin errors++; $display("FAIL cont_line_done: got %0d expected 3", ndone); end
    checks++; if (nwin !== 3*NWIN) begin errors++; $display("FAIL cont_window_count: got %0d expected %0d", nwin, 3*NWIN); end
    checks++; if (max_lf > NL) begin errors++; $display("FAIL cont_lines_full_max: got %0d expected <= %0d", max_lf, NL); end
  endtask

  task automatic test_backpressure();
    int ndone = 0, nwin = 0;
    bit hold = 0;
    logic [W*W*PW-1:0] exp, prev;
    do_reset();
    start_feed(W*LW, 1'b1);
    for (int i = 0; i < 7000 && ndone < 1; i++) begin
      win_ready = ((cyc / 3) % 2) == 0;
      if (hold) begin
        checks++; if (win_valid !== 1'b1 || window !== prev) begin errors++; $display("FAIL bp_hold: got valid %b window %h expected valid 1 window %h", win_valid, window, prev); end
      end
      hold = win_valid && !win_ready;
      prev = window;
      if (line_done) ndone++;
      if (win_valid && win_ready) begin
        exp = win_expected(rd_pass, rd_col);
        checks++; if (window !== exp) begin errors++; $display("FAIL bp_window p%0d k%0d: got %h expected %h", rd_pass, rd_col, window, exp); end
        nwin++; rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL bp_line_done: got %0d expected 1", ndone); end
    checks++; if (nwin !== NWIN) begin errors++; $display("FAIL bp_window_count: got %0d expected %0d", nwin, NWIN); end
  endtask

  task automatic test_overflow();
    int ndone = 0, nwin = 0;
    logic [W*W*PW-1:0] exp;
    do_reset();
    start_feed(NL*LW, 1'b1);
    for (int i = 0; i < 5000 && acc_cnt < NL*LW; i++) tick();
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_low: got %b expected 0", pix_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    pix_valid = 1'b1;
    pix_data  = ~lines[0][0];
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    win_ready = 1'b1;
    for (int i = 0; i < 800 && ndone < 1; i++) begin
      if (line_done) ndone++;
      if (win_valid && win_ready) begin
        exp = win_expected(rd_pass, rd_col);
        checks++; if (window !== exp) begin errors++; $display("FAIL ovf_window p%0d k%0d: got %h expected %h", rd_pass, rd_col, window, exp); end
        nwin++; rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
    end
    checks++; if (nwin !== NWIN) begin errors++; $display("FAIL ovf_window_count: got %0d expected %0d", nwin, NWIN); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_back: got %b expected 1", pix_ready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_simultaneous();
    int ndone = 0;
    bit hit = 0;
    logic [W*W*PW-1:0] exp;
    do_reset();
    win_ready = 1'b1;
    start_feed(NL*LW - 1, 1'b0);
    for (int i = 0; i < 7000 && ndone < 2; i++) begin
      if (line_done) begin
        ndone++;
        if (ndone == 1) begin
          checks++; if (acc_cnt !== NL*LW - 1) begin errors++; $display("FAIL sim_setup: got %0d pixels expected %0d", acc_cnt, NL*LW - 1); end
          feed_target = NL*LW;
          pix_valid   = pix_ready;
          pix_data    = src_pix(acc_cnt);
          hit         = 1;
        end
      end
      if (win_valid && win_ready) begin
        exp = win_expected(rd_pass, rd_col);
        checks++; if (window !== exp) begin errors++; $display("FAIL sim_window p%0d k%0d: got %h expected %h", rd_pass, rd_col, window, exp); end
        rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
      if (hit) begin
        hit = 0;
        checks++; if (int'(dut.lines_full) !== acc_cnt/LW - rd_pass) begin errors++; $display("FAIL sim_lines_full: got %0d expected %0d", dut.lines_full, acc_cnt/LW - rd_pass); end
      end
    end
    checks++; if (ndone !== 2) begin errors++; $display("FAIL sim_line_done: got %0d expected 2", ndone); end
  endtask

  task automatic test_reset_mid_window();
    int seen = 0, ndone = 0, nwin = 0, first_v = -1;
    logic [W*W*PW-1:0] exp;
    do_reset();
    win_ready = 1'b1;
    start_feed(W*LW, 1'b1);
    for (int i = 0; i < 5000 && !(win_valid && rd_col == 200); i++) begin
      if (win_valid && win_ready) begin
        rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rmw_async_valid: got %b expected 0", win_valid); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rmw_async_ready: got %b expected 1", pix_ready); end
    @(negedge clk);
    do_reset();
    win_ready = 1'b1;
    start_feed(5*LW, 1'b1);
    for (int i = 0; i < 5*LW + 600; i++) begin
      if (win_valid || line_done) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmw_early_output: got %0d active cycles expected 0", seen); end
    start_feed(W*LW, 1'b1);
    for (int i = 0; i < 1400 && ndone < 1; i++) begin
      if (win_valid && first_v < 0) first_v = cyc;
      if (line_done) ndone++;
      if (win_valid && win_ready) begin
        exp = win_expected(rd_pass, rd_col);
        checks++; if (window !== exp) begin errors++; $display("FAIL rmw_window p%0d k%0d: got %h expected %h", rd_pass, rd_col, window, exp); end
        nwin++; rd_col++; if (rd_col == NWIN) begin rd_col = 0; rd_pass++; end
      end
      tick();
    end
    checks++; if (first_v - edge6 !== 2) begin errors++; $display("FAIL rmw_latency: got %0d edges expected 2", first_v - edge6); end
    checks++; if (nwin !== NWIN) begin errors++; $display("FAIL rmw_window_count: got %0d expected %0d", nwin, NWIN); end
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    win_ready = 1'b0;
    rand_src  = 1'b0;
    test_reset();
    test_stream();
    test_continuous();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
